hack_memory_controller: RTL
===========================

Name: hack_memory_controller

Overview:
- Memory-side responder for the Hack `cpu` block: it drives `instruction`, `in_m` and `hold`, and consumes `pc`, `address_m`, `out_m` and `write_m`.
- It serialises instruction fetch, data read and data write onto one shared synchronous single-port memory (SPRAM-style, fixed read latency).
- It stalls the CPU with `hold` until both operands are ready.
- It sits between `u_cpu` and the memory/SPRAM wrapper in the top-level computer.

Parameters:
- MEM_LATENCY, 1: cycles from `mem_read_en` until `mem_rdata` is valid; legal range 1..4.
- SKIP_UNUSED_READ, 1: when 1, skip the data read for instructions that do not use M (A-instructions, and C-instructions with bit12=0).

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_pc  in  15  address of the next instruction.
- cpu_address_m  in  15  data address (CPU A register).
- cpu_out_m  in  16  data to write.
- cpu_write_m  in  1  write strobe; CPU masks it with hold, so it is only meaningful while cpu_hold=0.
- cpu_instruction  out  16  instruction for the CPU to execute.
- cpu_in_m  out  16  RAM[address_m] for the CPU.
- cpu_hold  out  1  1 = CPU must not advance.
- mem_address  out  16  bit15: 1=instruction region, 0=data region; bits[14:0] = word address.
- mem_read_en  out  1  one-cycle read request.
- mem_write_en  out  1  one-cycle write request (data region only).
- mem_wdata  out  16  write data.
- mem_rdata  in  16  read data, valid exactly MEM_LATENCY cycles after mem_read_en.

Behaviour:
- States: RESET_IDLE, I_REQ, I_WAIT, D_REQ, D_WAIT, EXEC. State is registered; cpu_hold = (state != EXEC), decoded from the state register.
- Reset (async, any state, including mid-wait):
  - state=RESET_IDLE, cpu_hold=1.
  - cpu_instruction=16'h0000, data latch=16'h0000.
  - mem_read_en=0, mem_write_en=0, mem_address=0, wait counter=0.
  - Any in-flight read is discarded.
- RESET_IDLE -> I_REQ on the first edge after reset_n releases.
- I_REQ (1 cycle): mem_read_en=1, mem_address={1'b1,cpu_pc}; counter loads MEM_LATENCY. -> I_WAIT.
- I_WAIT: counter decrements each cycle. On the cycle it reaches the final count, capture mem_rdata into cpu_instruction, then:
  - -> D_REQ if the captured instruction needs M, or if SKIP_UNUSED_READ=0;
  - otherwise -> EXEC.
  - "Needs M" = bit15=1 and bit12=1.
- D_REQ (1 cycle): mem_read_en=1, mem_address={1'b0,cpu_address_m}. -> D_WAIT.
- D_WAIT: same counting as I_WAIT; capture mem_rdata into the data latch. -> EXEC.
- EXEC (exactly 1 cycle, cpu_hold=0): the CPU executes on the edge that ends EXEC.
  - If cpu_write_m=1 (the write from the previously executed instruction): mem_write_en=1, mem_address={1'b0,cpu_address_m}, mem_wdata=cpu_out_m; the write commits on that edge.
  - -> I_REQ.
- cpu_in_m is combinational: cpu_in_m = (state==EXEC && cpu_write_m) ? cpu_out_m : data latch.
  - This forwarding covers the write-then-read hazard: the D_REQ read happened before the pending write committed, and read and write both use cpu_address_m.
- Never assert mem_read_en and mem_write_en in the same cycle. mem_write_en is only ever asserted in EXEC.
- cpu_write_m outside EXEC is ignored.
- cpu_pc and cpu_address_m are sampled only in I_REQ, D_REQ and EXEC; the CPU keeps them stable while held.
- Period per instruction:
  - with data read: 2*(MEM_LATENCY+1)+1 cycles;
  - without data read: MEM_LATENCY+2 cycles.
- mem_rdata outside capture cycles is ignored.

Test Plan:
- Reset mid-operation: pulse reset_n low while in D_WAIT -> cpu_hold=1 and mem_read_en=0 immediately (asynchronous). On release: RESET_IDLE one cycle, then I_REQ with mem_address=16'h8000|pc.
- A-instruction (MEM_LATENCY=1): ROM[0]=16'd123 -> no data-region read issued; cpu_hold low exactly 1 cycle in 3; cpu_instruction=16'd123 during EXEC.
- D=M read: RAM[123]=16'd7, instruction 16'hFC10, address_m=123 -> mem_address=16'h007B read in D_REQ; cpu_in_m=7 in EXEC; period = 5 cycles.
- Write forwarding: previous instruction M=D leaves write_m=1, out_m=246, address_m=246; current instruction D=M -> in EXEC: mem_write_en=1, mem_address=16'h00F6, mem_wdata=246, cpu_in_m=246 (the stale RAM value 0 is bypassed). The following read of RAM[246] returns 246.
- MEM_LATENCY=3: instruction needing M -> 9-cycle period; A-instruction -> 5-cycle period. Returned data is captured exactly 3 cycles after each mem_read_en; garbage on mem_rdata in other cycles has no effect.
- Held write ignored: force cpu_write_m=1 while cpu_hold=1 in I_WAIT -> mem_write_en stays 0. Also check that mem_read_en and mem_write_en are never both high over 1000 random-program cycles.

Source files
------------

// File: rtl/hack_memory_controller.sv
// Memory-side responder for the Hack CPU: serialises instruction fetch, data read and
// data write onto one fixed-latency single-port memory, holding the CPU until both are ready.
module hack_memory_controller #(
  parameter int unsigned MEM_LATENCY      = 1,
  parameter bit          SKIP_UNUSED_READ = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [14:0] cpu_pc,
  input  logic [14:0] cpu_address_m,
  input  logic [15:0] cpu_out_m,
  input  logic        cpu_write_m,
  output logic [15:0] cpu_instruction,
  output logic [15:0] cpu_in_m,
  output logic        cpu_hold,
  output logic [15:0] mem_address,
  output logic        mem_read_en,
  output logic        mem_write_en,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [2:0] {
    StResetIdle,
    StIReq,
    StIWait,
    StDReq,
    StDWait,
    StExec
  } state_e;

  localparam logic [2:0] LatCount = 3'(MEM_LATENCY);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] data_q, data_d;
  logic        needs_m;

  // Only C-instructions with the a-bit set read M.
  assign needs_m = mem_rdata[15] & mem_rdata[12];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    instr_d      = instr_q;
    data_d       = data_q;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    mem_address  = 16'h0000;
    mem_wdata    = 16'h0000;
    unique case (state_q)
      StResetIdle: state_d = StIReq;
      StIReq: begin
        mem_read_en = 1'b1;
        mem_address = {1'b1, cpu_pc};
        cnt_d       = LatCount;
        state_d     = StIWait;
      end
      StIWait: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          instr_d = mem_rdata;
          state_d = (needs_m || !SKIP_UNUSED_READ) ? StDReq : StExec;
        end
      end
      StDReq: begin
        mem_read_en = 1'b1;
        mem_address = {1'b0, cpu_address_m};
        cnt_d       = LatCount;
        state_d     = StDWait;
      end
      StDWait: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          data_d  = mem_rdata;
          state_d = StExec;
        end
      end
      StExec: begin
        // Commit the previous instruction's pending write on the edge ending EXEC.
        if (cpu_write_m) begin
          mem_write_en = 1'b1;
          mem_address  = {1'b0, cpu_address_m};
          mem_wdata    = cpu_out_m;
        end
        state_d = StIReq;
      end
      default: state_d = StResetIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StResetIdle;
      cnt_q   <= 3'd0;
      instr_q <= 16'h0000;
      data_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      data_q  <= data_d;
    end
  end

  assign cpu_hold        = (state_q != StExec);
  assign cpu_instruction = instr_q;
  // The data read happened before the pending write commits, so forward it.
  assign cpu_in_m        = (state_q == StExec && cpu_write_m) ? cpu_out_m : data_q;

endmodule
